// File: rtl/xs3_to_bin_seq.sv
// Sequential excess-3 to binary converter: accepts one NDIG-digit word, folds one digit
// per cycle (MSD first) into a 14-bit accumulator, then holds the result until taken.
module xs3_to_bin_seq #(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4*NDIG-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [13:0]       bin_out,
   output logic              err,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   state_t            state;
   logic [4*NDIG-1:0] data_q;
   logic [13:0]       acc;
   logic              err_acc;
   logic [2:0]        cnt;

   logic [3:0]        digit;
   logic              digit_ok;
   logic [13:0]       digit_val;

   // The digit under conversion is always the top nibble; the word shifts left each CONV cycle.
   assign digit     = data_q[4*NDIG-1 -: 4];
   assign digit_ok  = (digit >= 4'd3) && (digit <= 4'd12);
   assign digit_val = digit_ok ? {10'd0, digit - 4'd3} : 14'd0;

   // in_ready is registered so it stays low during reset and rises one edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         data_q    <= '0;
         acc       <= '0;
         err_acc   <= 1'b0;
         cnt       <= '0;
         in_ready  <= 1'b0;
         bin_out   <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  data_q   <= in_data;
                  acc      <= '0;
                  err_acc  <= 1'b0;
                  cnt      <= 3'(NDIG - 1);
                  in_ready <= 1'b0;
                  state    <= CONV;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            CONV: begin
               acc     <= acc * 14'd10 + digit_val;
               err_acc <= err_acc | ~digit_ok;
               data_q  <= data_q << 4;
               if (cnt == 3'd0) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            DONE: begin
               // First DONE cycle registers the result; afterwards wait for the consumer.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  err       <= err_acc;
                  bin_out   <= err_acc ? 14'd0 : acc;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
